// File: rtl/alu_seq.sv
// alu_seq: sequential ALU. Single-cycle ops register their result at the accept edge and stay busy for one cycle.
// Define ALU_SEQ_MUL_EN to build the WIDTH-cycle shift-add multiplier for opcode 1000; otherwise 1000 is illegal.
module alu_seq #(
    parameter int WIDTH = 8,
    parameter int INC   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       ALUop,
    output logic [WIDTH-1:0] C,
    output logic [WIDTH-1:0] C_hi,
    output logic [3:0]       Cond,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int               MSB   = WIDTH - 1;
    localparam logic [WIDTH-1:0] INC_W = WIDTH'(INC);

    typedef enum logic [1:0] {
        IDLE,
        EXEC
`ifdef ALU_SEQ_MUL_EN
        ,MUL
`endif
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] c_q, c_d;
    logic [3:0]       cond_q, cond_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic [WIDTH-1:0] alu_res;
    logic [3:0]       alu_cond;
    logic             alu_cf;
    logic             alu_vf;
    logic             alu_illegal;

`ifdef ALU_SEQ_MUL_EN
    localparam int               CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    logic                 alu_is_mul;
    logic [WIDTH-1:0]     c_hi_q, c_hi_d;
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic [2*WIDTH-1:0]   prod_q, prod_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [WIDTH:0]       mul_sum;

    // Low half of prod starts as the multiplier and is consumed one bit per step from the LSB.
    assign mul_sum = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
`endif

    always_comb begin : alu
        alu_res     = '0;
        alu_cf      = 1'b0;
        alu_vf      = 1'b0;
        alu_illegal = 1'b0;
`ifdef ALU_SEQ_MUL_EN
        alu_is_mul  = 1'b0;
`endif
        case (ALUop)
            4'b0000: alu_res = '0;
            4'b0001: begin
                {alu_cf, alu_res} = {1'b0, A} + {1'b0, B};
                alu_vf = (A[MSB] == B[MSB]) && (alu_res[MSB] != A[MSB]);
            end
            4'b0010: begin
                alu_res = A - B;
                alu_cf  = (A < B);
                alu_vf  = (A[MSB] != B[MSB]) && (alu_res[MSB] != A[MSB]);
            end
            4'b0011: begin
                alu_res = '0 - B;
                alu_cf  = |B;
                alu_vf  = (B == {1'b1, {(WIDTH-1){1'b0}}});
            end
            4'b0100: alu_res = A & B;
            4'b0101: alu_res = A | B;
            4'b0110: alu_res = A ^ B;
            4'b0111: alu_res = ~B;
            4'b1001: alu_res = B;
            4'b1010: begin
                alu_res = {A[MSB-1:0], 1'b0};
                alu_cf  = A[MSB];
            end
            4'b1011: begin
                alu_res = {1'b0, A[MSB:1]};
                alu_cf  = A[0];
            end
            4'b1100: alu_res = {A[MSB-1:0], A[MSB]};
            4'b1101: alu_res = {A[0], A[MSB:1]};
            4'b1110: begin
                {alu_cf, alu_res} = {1'b0, A} + {1'b0, INC_W};
                alu_vf = (A[MSB] == INC_W[MSB]) && (alu_res[MSB] != A[MSB]);
            end
            4'b1000: begin
`ifdef ALU_SEQ_MUL_EN
                alu_is_mul  = 1'b1;
`else
                alu_illegal = 1'b1;
`endif
            end
            default: alu_illegal = 1'b1;
        endcase
        alu_cond = (ALUop == 4'b0000) ? 4'b1000 : {alu_res == '0, alu_res[MSB], alu_cf, alu_vf};
    end

    always_comb begin : next_state
        state_d = state_q;
        c_d     = c_q;
        cond_d  = cond_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
`ifdef ALU_SEQ_MUL_EN
        c_hi_d  = c_hi_q;
        mcand_d = mcand_q;
        prod_d  = prod_q;
        cnt_d   = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    busy_d = 1'b1;
`ifdef ALU_SEQ_MUL_EN
                    if (alu_is_mul) begin
                        state_d = MUL;
                        mcand_d = A;
                        prod_d  = {{WIDTH{1'b0}}, B};
                        cnt_d   = '0;
                    end else begin
`endif
                        // Illegal opcodes still pulse done but leave the result registers untouched.
                        state_d = EXEC;
                        done_d  = 1'b1;
                        err_d   = alu_illegal;
                        if (!alu_illegal) begin
                            c_d    = alu_res;
                            cond_d = alu_cond;
`ifdef ALU_SEQ_MUL_EN
                            c_hi_d = '0;
`endif
                        end
`ifdef ALU_SEQ_MUL_EN
                    end
`endif
                end
            end
            EXEC: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
`ifdef ALU_SEQ_MUL_EN
            MUL: begin
                prod_d = {mul_sum, prod_q[WIDTH-1:1]};
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    c_d     = prod_d[WIDTH-1:0];
                    c_hi_d  = prod_d[2*WIDTH-1:WIDTH];
                    cond_d  = {prod_d == '0, prod_d[2*WIDTH-1],
                               |prod_d[2*WIDTH-1:WIDTH], |prod_d[2*WIDTH-1:WIDTH]};
                end
            end
`endif
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            c_q     <= '0;
            cond_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
            c_hi_q  <= '0;
            mcand_q <= '0;
            prod_q  <= '0;
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            c_q     <= c_d;
            cond_q  <= cond_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
`ifdef ALU_SEQ_MUL_EN
            c_hi_q  <= c_hi_d;
            mcand_q <= mcand_d;
            prod_q  <= prod_d;
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign C    = c_q;
    assign Cond = cond_q;
    assign busy = busy_q;
    assign done = done_q;
    assign err  = err_q;
`ifdef ALU_SEQ_MUL_EN
    assign C_hi = c_hi_q;
`else
    assign C_hi = '0;
`endif

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: a reference model pushes the expected result of every accepted
// request onto a scoreboard that is popped on each done pulse. MUL scenarios need ALU_SEQ_MUL_EN.
module tb_alu_seq;
    localparam int WIDTH = 8;
    localparam int INC   = 4;
    localparam int MAXS  = (1 << (WIDTH - 1)) - 1;
    localparam int MINS  = -(1 << (WIDTH - 1));
    localparam int MODW  = 1 << WIDTH;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [3:0]       ALUop;
    logic [WIDTH-1:0] C;
    logic [WIDTH-1:0] C_hi;
    logic [3:0]       Cond;
    logic             busy;
    logic             done;
    logic             err;

    typedef struct {
        logic [WIDTH-1:0] c;
        logic [WIDTH-1:0] c_hi;
        logic [3:0]       cond;
        logic             err;
        int               lat;
    } exp_t;

    exp_t             sb[$];
    logic [WIDTH-1:0] m_c;
    logic [WIDTH-1:0] m_c_hi;
    logic [3:0]       m_cond;
    int               n_checks = 0;
    int               n_fails  = 0;

    alu_seq #(.WIDTH(WIDTH), .INC(INC)) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .A    (A),
        .B    (B),
        .ALUop(ALUop),
        .C    (C),
        .C_hi (C_hi),
        .Cond (Cond),
        .busy (busy),
        .done (done),
        .err  (err)
    );

    always #5 clk = ~clk;

    // Reference model written in integer arithmetic; it also tracks the held output registers.
    task automatic model_push(input logic [3:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        exp_t             e;
        int               ua, ub, sa, sbv, r;
        longint           p;
        logic [WIDTH-1:0] res;
        logic             cf, vf, illegal, is_mul;
        ua  = int'(a);
        ub  = int'(b);
        sa  = int'($signed(a));
        sbv = int'($signed(b));
        if (op == 4'hE) begin
            ub  = INC % MODW;
            sbv = (ub > MAXS) ? ub - MODW : ub;
        end
        cf = 1'b0; vf = 1'b0; illegal = 1'b0; is_mul = 1'b0; res = '0; p = 0; r = 0;
        e.lat = 1; e.c = '0; e.c_hi = '0; e.cond = '0; e.err = 1'b0;
        case (op)
            4'h0: res = '0;
            4'h1, 4'hE: begin
                r = ua + ub; res = r[WIDTH-1:0]; cf = (r >= MODW);
                vf = (sa + sbv > MAXS) || (sa + sbv < MINS);
            end
            4'h2: begin
                r = ua - ub; res = r[WIDTH-1:0]; cf = (ua < ub);
                vf = (sa - sbv > MAXS) || (sa - sbv < MINS);
            end
            4'h3: begin r = -ub; res = r[WIDTH-1:0]; cf = (ub != 0); vf = (-sbv > MAXS); end
            4'h4: res = a & b;
            4'h5: res = a | b;
            4'h6: res = a ^ b;
            4'h7: res = ~b;
            4'h9: res = b;
            4'hA: begin r = (ua * 2) % MODW; res = r[WIDTH-1:0]; cf = (ua > MAXS); end
            4'hB: begin r = ua / 2; res = r[WIDTH-1:0]; cf = (ua % 2 == 1); end
            4'hC: begin r = (ua * 2) % MODW + ua / (MAXS + 1); res = r[WIDTH-1:0]; end
            4'hD: begin r = ua / 2 + (ua % 2) * (MAXS + 1); res = r[WIDTH-1:0]; end
            4'h8: begin
`ifdef ALU_SEQ_MUL_EN
                is_mul = 1'b1; p = longint'(ua) * longint'(ub); e.lat = WIDTH + 1;
`else
                illegal = 1'b1;
`endif
            end
            default: illegal = 1'b1;
        endcase
        if (illegal) begin
            e.c = m_c; e.c_hi = m_c_hi; e.cond = m_cond; e.err = 1'b1;
        end else if (is_mul) begin
            e.c    = p[WIDTH-1:0];
            e.c_hi = p[2*WIDTH-1:WIDTH];
            e.cond = {p == 0, p[2*WIDTH-1], p >= longint'(MODW), p >= longint'(MODW)};
        end else begin
            e.c    = res;
            e.cond = (op == 4'h0) ? 4'b1000 : {res == '0, res[WIDTH-1], cf, vf};
        end
        m_c = e.c; m_c_hi = e.c_hi; m_cond = e.cond;
        sb.push_back(e);
    endtask

    task automatic model_reset();
        sb.delete();
        m_c = '0; m_c_hi = '0; m_cond = '0;
    endtask

    // Drives one request into an idle DUT; returns just after the accept edge.
    task automatic issue(input logic [3:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        @(negedge clk);
        start = 1'b1; ALUop = op; A = a; B = b;
        model_push(op, a, b);
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Waits (bounded) for done and returns observed outputs with the popped expectation.
    task automatic collect(output exp_t got, output exp_t exp);
        got.lat = -1;
        for (int i = 1; i <= 2 * WIDTH + 4; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                got.lat = i;
                break;
            end
        end
        got.c = C; got.c_hi = C_hi; got.cond = Cond; got.err = err;
        if (sb.size() > 0) exp = sb.pop_front();
        else begin
            exp.c = 'x; exp.c_hi = 'x; exp.cond = 'x; exp.err = 1'bx; exp.lat = -2;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; A = 8'h7F; B = 8'h01; ALUop = 4'h1;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({C, C_hi, Cond} !== '0) begin
            n_fails++;
            $display("[TB] FAIL reset_outputs: got C=%h C_hi=%h Cond=%b, expected all 0", C, C_hi, Cond);
        end
        n_checks++;
        if ({busy, done, err} !== 3'b000) begin
            n_fails++;
            $display("[TB] FAIL reset_status: got busy/done/err=%b, expected 000", {busy, done, err});
        end
        rst = 1'b0; start = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({busy, done, err, C} !== '0) begin
            n_fails++;
            $display("[TB] FAIL reset_idle: got busy=%b done=%b err=%b C=%h, expected idle zeros", busy, done, err, C);
        end
    endtask

    task automatic test_spec_vectors();
        logic [3:0]       t_op [5];
        logic [WIDTH-1:0] t_a  [5];
        logic [WIDTH-1:0] t_b  [5];
        logic [WIDTH-1:0] t_c  [5];
        logic [3:0]       t_cd [5];
        exp_t             got, exp;
        t_op = '{4'h1, 4'h2, 4'h2, 4'hD, 4'hA};
        t_a  = '{8'h7F, 8'h05, 8'h03, 8'h01, 8'h81};
        t_b  = '{8'h01, 8'h05, 8'h05, 8'h00, 8'h00};
        t_c  = '{8'h80, 8'h00, 8'hFE, 8'h80, 8'h02};
        t_cd = '{4'b0101, 4'b1000, 4'b0110, 4'b0100, 4'b0010};
        for (int i = 0; i < 5; i++) begin
            issue(t_op[i], t_a[i], t_b[i]);
            collect(got, exp);
            n_checks++;
            if (got.lat !== exp.lat) begin
                n_fails++;
                $display("[TB] FAIL vec%0d_latency: got %0d, expected %0d", i, got.lat, exp.lat);
            end
            n_checks++;
            if ({got.c, got.c_hi, got.cond, got.err} !== {exp.c, exp.c_hi, exp.cond, exp.err}) begin
                n_fails++;
                $display("[TB] FAIL vec%0d_scoreboard: got C=%h C_hi=%h Cond=%b err=%b, expected C=%h C_hi=%h Cond=%b err=%b",
                         i, got.c, got.c_hi, got.cond, got.err, exp.c, exp.c_hi, exp.cond, exp.err);
            end
            n_checks++;
            if ({got.c, got.cond} !== {t_c[i], t_cd[i]}) begin
                n_fails++;
                $display("[TB] FAIL vec%0d_literal: got C=%h Cond=%b, expected C=%h Cond=%b",
                         i, got.c, got.cond, t_c[i], t_cd[i]);
            end
        end
    endtask

    task automatic test_all_ops();
        logic [WIDTH-1:0] a, b;
        exp_t             got, exp;
        for (int pass = 0; pass < 4; pass++) begin
            for (int op = 0; op < 16; op++) begin
                case (pass)
                    0: begin a = 8'h80; b = 8'h80; end
                    1: begin a = 8'h00; b = 8'h00; end
                    2: begin a = 8'hFF; b = 8'h01; end
                    default: begin a = WIDTH'($urandom_range(0, MODW - 1)); b = WIDTH'($urandom_range(0, MODW - 1)); end
                endcase
                issue(4'(op), a, b);
                collect(got, exp);
                n_checks++;
                if (got.lat !== exp.lat) begin
                    n_fails++;
                    $display("[TB] FAIL op%h_latency: got %0d, expected %0d (A=%h B=%h)", op, got.lat, exp.lat, a, b);
                end
                n_checks++;
                if ({got.c, got.c_hi, got.cond, got.err} !== {exp.c, exp.c_hi, exp.cond, exp.err}) begin
                    n_fails++;
                    $display("[TB] FAIL op%h_result: A=%h B=%h got C=%h C_hi=%h Cond=%b err=%b, expected C=%h C_hi=%h Cond=%b err=%b",
                             op, a, b, got.c, got.c_hi, got.cond, got.err, exp.c, exp.c_hi, exp.cond, exp.err);
                end
            end
        end
    endtask

    task automatic test_illegal();
        exp_t got, exp;
        logic [3:0] bad_ops [2];
        int n_bad;
        bad_ops[0] = 4'hF;
        bad_ops[1] = 4'h8;
`ifdef ALU_SEQ_MUL_EN
        n_bad = 1;
`else
        n_bad = 2;
`endif
        for (int k = 0; k < n_bad; k++) begin
            issue(4'h1, 8'h7F, 8'h01);
            collect(got, exp);
            n_checks++;
            if ({got.c, got.cond, got.err} !== {exp.c, exp.cond, exp.err}) begin
                n_fails++;
                $display("[TB] FAIL illegal_setup: got C=%h Cond=%b err=%b, expected C=%h Cond=%b err=%b",
                         got.c, got.cond, got.err, exp.c, exp.cond, exp.err);
            end
            issue(bad_ops[k], 8'h11, 8'h22);
            collect(got, exp);
            n_checks++;
            if (got.lat !== 1 || got.err !== 1'b1) begin
                n_fails++;
                $display("[TB] FAIL illegal_%h_err: got latency=%0d err=%b, expected latency=1 err=1", bad_ops[k], got.lat, got.err);
            end
            n_checks++;
            if ({got.c, got.c_hi, got.cond} !== {8'h80, 8'h00, 4'b0101}) begin
                n_fails++;
                $display("[TB] FAIL illegal_%h_hold: got C=%h C_hi=%h Cond=%b, expected C=80 C_hi=00 Cond=0101",
                         bad_ops[k], got.c, got.c_hi, got.cond);
            end
            @(negedge clk);
            n_checks++;
            if ({done, err} !== 2'b00) begin
                n_fails++;
                $display("[TB] FAIL illegal_%h_pulse: got done/err=%b one cycle later, expected 00", bad_ops[k], {done, err});
            end
        end
    endtask

    // Start held high every cycle: every other request lands in EXEC and must be dropped.
    task automatic test_back_to_back();
        logic [3:0] op;
        logic       exp_d;
        exp_t       e;
        @(negedge clk);
        for (int k = 0; k < 10; k++) begin
            op = 4'($urandom_range(0, 15));
            if (op == 4'h8) op = 4'h9;
            start = 1'b1; ALUop = op;
            A = WIDTH'($urandom_range(0, MODW - 1));
            B = WIDTH'($urandom_range(0, MODW - 1));
            exp_d = (k % 2 == 0);
            if (exp_d) model_push(op, A, B);
            @(negedge clk);
            n_checks++;
            if ({done, busy} !== {exp_d, exp_d}) begin
                n_fails++;
                $display("[TB] FAIL b2b%0d_handshake: got done=%b busy=%b, expected done=%b busy=%b", k, done, busy, exp_d, exp_d);
            end
            if (exp_d && sb.size() > 0) begin
                e = sb.pop_front();
            end else begin
                e.c = m_c; e.c_hi = m_c_hi; e.cond = m_cond; e.err = 1'b0;
            end
            n_checks++;
            if ({C, C_hi, Cond, err} !== {e.c, e.c_hi, e.cond, e.err}) begin
                n_fails++;
                $display("[TB] FAIL b2b%0d_outputs: got C=%h C_hi=%h Cond=%b err=%b, expected C=%h C_hi=%h Cond=%b err=%b",
                         k, C, C_hi, Cond, err, e.c, e.c_hi, e.cond, e.err);
            end
        end
        start = 1'b0;
    endtask

`ifdef ALU_SEQ_MUL_EN
    task automatic test_mul();
        exp_t             got, exp;
        logic [WIDTH-1:0] ma [4];
        logic [WIDTH-1:0] mb [4];
        issue(4'h8, 8'hFF, 8'hFF);
        for (int i = 1; i <= WIDTH + 1; i++) begin
            @(negedge clk);
            n_checks++;
            if ({busy, done} !== {i <= WIDTH, i == WIDTH + 1}) begin
                n_fails++;
                $display("[TB] FAIL mul_cycle%0d: got busy=%b done=%b, expected busy=%b done=%b",
                         i, busy, done, i <= WIDTH, i == WIDTH + 1);
            end
            start = (i <= WIDTH);
            ALUop = 4'h1; A = WIDTH'(i); B = 8'h33;
        end
        start = 1'b0;
        exp = sb.pop_front();
        n_checks++;
        if ({C_hi, C, Cond, err} !== {exp.c_hi, exp.c, exp.cond, exp.err}) begin
            n_fails++;
            $display("[TB] FAIL mul_ff_scoreboard: got C_hi=%h C=%h Cond=%b err=%b, expected C_hi=%h C=%h Cond=%b err=%b",
                     C_hi, C, Cond, err, exp.c_hi, exp.c, exp.cond, exp.err);
        end
        n_checks++;
        if ({C_hi, C, Cond} !== {8'hFE, 8'h01, 4'b0111}) begin
            n_fails++;
            $display("[TB] FAIL mul_ff_literal: got C_hi=%h C=%h Cond=%b, expected C_hi=fe C=01 Cond=0111", C_hi, C, Cond);
        end
        ma = '{8'h00, 8'h10, 8'h0D, WIDTH'($urandom_range(0, MODW - 1))};
        mb = '{8'h5A, 8'h10, 8'h07, WIDTH'($urandom_range(0, MODW - 1))};
        for (int i = 0; i < 4; i++) begin
            issue(4'h8, ma[i], mb[i]);
            collect(got, exp);
            n_checks++;
            if (got.lat !== exp.lat) begin
                n_fails++;
                $display("[TB] FAIL mul%0d_latency: got %0d, expected %0d", i, got.lat, exp.lat);
            end
            n_checks++;
            if ({got.c, got.c_hi, got.cond, got.err} !== {exp.c, exp.c_hi, exp.cond, exp.err}) begin
                n_fails++;
                $display("[TB] FAIL mul%0d_result: A=%h B=%h got C_hi=%h C=%h Cond=%b err=%b, expected C_hi=%h C=%h Cond=%b err=%b",
                         i, ma[i], mb[i], got.c_hi, got.c, got.cond, got.err, exp.c_hi, exp.c, exp.cond, exp.err);
            end
        end
    endtask

    task automatic test_mul_abort();
        exp_t got, exp;
        int   n_done;
        issue(4'h8, 8'h12, 8'h34);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        n_checks++;
        if ({C, C_hi, Cond, busy, done, err} !== '0) begin
            n_fails++;
            $display("[TB] FAIL abort_clear: got C=%h C_hi=%h Cond=%b busy=%b done=%b err=%b, expected all 0",
                     C, C_hi, Cond, busy, done, err);
        end
        n_done = 0;
        for (int i = 0; i < 2 * WIDTH; i++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) n_done++;
        end
        n_checks++;
        if (n_done !== 0) begin
            n_fails++;
            $display("[TB] FAIL abort_no_done: got %0d busy/done cycles after abort, expected 0", n_done);
        end
        issue(4'h1, 8'h7F, 8'h01);
        collect(got, exp);
        n_checks++;
        if (got.lat !== 1 || {got.c, got.c_hi, got.cond} !== {exp.c, exp.c_hi, exp.cond}) begin
            n_fails++;
            $display("[TB] FAIL abort_recover: got latency=%0d C=%h C_hi=%h Cond=%b, expected latency=1 C=%h C_hi=%h Cond=%b",
                     got.lat, got.c, got.c_hi, got.cond, exp.c, exp.c_hi, exp.cond);
        end
    endtask
`endif

    initial begin
        rst = 1'b1; start = 1'b0; A = '0; B = '0; ALUop = '0;
        test_reset();
        test_spec_vectors();
        test_all_ops();
        test_illegal();
        test_back_to_back();
`ifdef ALU_SEQ_MUL_EN
        test_mul();
        test_mul_abort();
`endif
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected bench to finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits; legal range 4..32.
REQ-002 Parameter INC, default 4, constant added by opcode 1110; truncated to WIDTH.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request; accepted only when busy=0.
REQ-006 A  input  WIDTH  operand A, sampled on accept.
REQ-007 B  input  WIDTH  operand B, sampled on accept.
REQ-008 ALUop  input  4  opcode, sampled on accept.
REQ-009 C  output  WIDTH  registered result (low half for MUL).
REQ-010 C_hi  output  WIDTH  registered high half of MUL product; 0 for all other ops.
REQ-011 Cond  output  4  registered flags {Z,N,C,V}, bit 3 = Z.
REQ-012 busy  output  1  high while an operation is in flight.
REQ-013 done  output  1  one-cycle pulse when C/C_hi/Cond are updated.
REQ-014 err  output  1  one-cycle pulse, coincident with done, for illegal opcode.

Function
REQ-015 States IDLE, EXEC, MUL; IDLE->EXEC on accepted non-MUL op, IDLE->MUL on accepted MUL, EXEC->IDLE after 1 cycle, MUL->IDLE after WIDTH cycles.
REQ-016 busy = 1 in EXEC and MUL; start ignored while busy (no queueing).
REQ-017 Single-cycle ops: done and new outputs visible exactly 1 cycle after accept edge (latency 1).
REQ-018 Opcodes: 0000 C=0,Cond=1000; 0001 A+B; 0010 A-B; 0011 -B; 0100 A&B; 0101 A|B; 0110 A^B; 0111 ~B; 1001 B; 1010 shl A (0 in); 1011 shr A logical (0 in); 1100 rotl A; 1101 rotr A; 1110 A+INC; 1000 MUL (unsigned A*B); 1111 illegal.
REQ-019 Z = (C==0); N = C[WIDTH-1] for every legal op except 0000.
REQ-020 ADD/A+INC: C flag = unsigned carry-out of bit WIDTH-1; V = signed overflow (same operand signs, result sign differs).
REQ-021 SUB: C flag = borrow = 1 iff A<B unsigned (A==B gives 0); V = operand signs differ and result sign differs from A.
REQ-022 NEG: V = 1 iff B = 100..0; C flag = 1 iff B != 0.
REQ-023 Logic, pass, shift, rotate ops: C flag = V = 0; shl sets C flag = A[WIDTH-1] shifted out, shr sets C flag = A[0].
REQ-024 MUL: shift-add, one partial product per cycle, WIDTH cycles in MUL state, done on the cycle leaving MUL (latency WIDTH+1 from accept); {C_hi,C} = full 2*WIDTH product; Z = product==0; N = C_hi[WIDTH-1]; C flag = V = (C_hi != 0).
REQ-025 Illegal opcode (1111, or 1000 when MUL compiled out): latency 1, done=1, err=1, C, C_hi, Cond hold previous values.
REQ-026 Outputs C, C_hi, Cond hold between done pulses; operand/opcode inputs changing while busy have no effect.
REQ-027 start asserted in the same cycle done pulses is not accepted (busy still 1); accepted next cycle after IDLE returns.

Reset
REQ-028 rst high at a clock edge: state IDLE, C=0, C_hi=0, Cond=0000, busy=0, done=0, err=0; overrides start.
REQ-029 rst during MUL aborts the operation; no done pulse is produced for it.

Configuration
REQ-030 Macro ALU_SEQ_MUL_EN defined: opcode 1000 performs MUL per REQ-024 and MUL state exists.
REQ-031 Macro ALU_SEQ_MUL_EN undefined: no multiplier logic or MUL state; 1000 is illegal per REQ-025; C_hi tied 0.

Verification (WIDTH=8, INC=4, ALU_SEQ_MUL_EN defined unless stated)
REQ-032 ADD A=0x7F B=0x01 -> one cycle later done=1, C=0x80, Cond=0101 (N,V).
REQ-033 SUB A=0x05 B=0x05 -> C=0x00, Cond=1000; SUB A=0x03 B=0x05 -> C=0xFE, Cond=0110.
REQ-034 MUL A=0xFF B=0xFF -> busy 8 cycles, done at accept+9, C_hi=0xFE, C=0x01, Cond=0111; start pulses during busy ignored.
REQ-035 rst asserted 3 cycles into MUL -> next cycle all outputs 0, busy=0, no done; new ADD accepted afterwards normally.
REQ-036 ALUop=1111 after ADD -> done=1, err=1, C/Cond unchanged; with macro undefined, ALUop=1000 gives the same.
REQ-037 rotr A=0x01 -> C=0x80, Cond=0100; shl A=0x81 -> C=0x02, Cond=0010.
